tlb_value_memory_multiport: RTL and testbench

Parametrised successor to the TLB value store: a DEPTH-entry table of DATA_WIDTH-bit values, each with a valid bit. It has READ_PORTS independent synchronous read ports and one read/write port. A built-in flush engine clears all entries one per cycle, both after reset and on request. It sits between the TLB key/match logic (read ports) and the TLB management instructions (write port).

---
 rtl/tlb_value_memory_multiport.sv | 130 +++++++++++++
 tb/tb_tlb_value_memory_multiport.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_value_memory_multiport.sv
// TLB value store: DEPTH x {valid, data} RAM, READ_PORTS read ports plus one write-first read/write port.
// Latency: 1 cycle on every read output; flush engine clears one entry per cycle (DEPTH cycles).
// Backpressure: writeReady low while flushing; writes offered then are dropped and must be retried.
module tlb_value_memory_multiport #(
    parameter int DATA_WIDTH    = 22,
    parameter int ADDRESS_WIDTH = 5,
    parameter int READ_PORTS    = 2,
    parameter int READ_BYPASS   = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] readIndex,
    output logic [READ_PORTS*DATA_WIDTH-1:0]    readData,
    output logic [READ_PORTS-1:0]               readValid,
    input  logic [ADDRESS_WIDTH-1:0]            writeIndex,
    input  logic [DATA_WIDTH-1:0]               writeData,
    input  logic                                writeValid,
    input  logic                                writeEnable,
    output logic                                writeReady,
    output logic [DATA_WIDTH-1:0]               writeReadData,
    output logic                                writeReadValid,
    input  logic                                flushRequest,
    output logic                                flushBusy
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]              cnt_q, cnt_d;
    logic [READ_PORTS-1:0][DATA_WIDTH:0]   rd_q, rd_d;
    logic [DATA_WIDTH:0]                   wr_rd_q, wr_rd_d;

    // Entry layout: {valid, data}. Not reset so it can map onto a RAM macro.
    logic [DATA_WIDTH:0]                   mem [DEPTH];

    logic                                  user_wr;
    logic                                  ram_we;
    logic [ADDRESS_WIDTH-1:0]              ram_waddr;
    logic [DATA_WIDTH:0]                   ram_wdat;

    assign flushBusy  = (state_q == ST_FLUSH);
    assign writeReady = !flushBusy;

    // Flush sequencer: sweep every entry once; further requests are ignored until the sweep ends.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (flushRequest) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                // Counter wraps to zero on the same edge that clears the last entry.
                cnt_d = cnt_q + ADDRESS_WIDTH'(1);
                if (cnt_q == {ADDRESS_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    // Single RAM write port shared by the flush engine and user writes; flush has priority.
    always_comb begin
        user_wr   = writeEnable && writeReady;
        ram_we    = flushBusy || user_wr;
        ram_waddr = flushBusy ? cnt_q : writeIndex;
        ram_wdat  = flushBusy ? '0 : {writeValid, writeData};
    end

    // Next read-port values: old contents, or forwarded write data when bypass is enabled.
    always_comb begin
        rd_d = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_d[p] = mem[readIndex[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
            if ((READ_BYPASS != 0) && ram_we &&
                (readIndex[p*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ram_waddr)) begin
                rd_d[p] = ram_wdat;
            end
        end
        // Read/write port is write-first for user writes only; flush writes show the stored entry.
        wr_rd_d = user_wr ? {writeValid, writeData} : mem[writeIndex];
    end

    // Unpack registered read-port entries onto the flat output buses.
    always_comb begin
        readData  = '0;
        readValid = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            readData[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p][DATA_WIDTH-1:0];
            readValid[p]                         = rd_q[p][DATA_WIDTH];
        end
        writeReadData  = wr_rd_q[DATA_WIDTH-1:0];
        writeReadValid = wr_rd_q[DATA_WIDTH];
    end

    // RAM write; suppressed while reset is held so reset never disturbs contents.
    always_ff @(posedge clock) begin
        if (reset && ram_we) begin
            mem[ram_waddr] <= ram_wdat;
        end
    end

    // Control and output registers; reset lands in FLUSH so the table is cleared after power-up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_rd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_rd_q <= wr_rd_d;
        end
    end

endmodule

// File: tb/tb_tlb_value_memory_multiport.sv
module tb_tlb_value_memory_multiport;

    localparam int DW    = 22;
    localparam int AW    = 5;
    localparam int NP    = 2;
    localparam int BYP   = 0;
    localparam int DEPTH = 1 << AW;

    logic               clock;
    logic               reset;
    logic [NP*AW-1:0]   readIndex;
    logic [NP*DW-1:0]   readData;
    logic [NP-1:0]      readValid;
    logic [AW-1:0]      writeIndex;
    logic [DW-1:0]      writeData;
    logic               writeValid;
    logic               writeEnable;
    logic               writeReady;
    logic [DW-1:0]      writeReadData;
    logic               writeReadValid;
    logic               flushRequest;
    logic               flushBusy;

    tlb_value_memory_multiport #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_PORTS(NP), .READ_BYPASS(BYP)
    ) dut (
        .clock(clock), .reset(reset),
        .readIndex(readIndex), .readData(readData), .readValid(readValid),
        .writeIndex(writeIndex), .writeData(writeData), .writeValid(writeValid),
        .writeEnable(writeEnable), .writeReady(writeReady),
        .writeReadData(writeReadData), .writeReadValid(writeReadValid),
        .flushRequest(flushRequest), .flushBusy(flushBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: table contents, which entries hold a defined value, flush edges remaining.
    logic [DW:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          flush_left;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: predict outputs from the model, advance, compare, then update the model.
    task automatic cycle();
        logic [DW:0] exp_rd [NP];
        bit          exp_rk [NP];
        logic [DW:0] exp_wr;
        bit          exp_wk;
        bit          acc;
        int          fi;
        int          idx;
        int          wi;
        acc = writeEnable && (flush_left == 0);
        fi  = DEPTH - flush_left;
        wi  = int'(writeIndex);
        for (int p = 0; p < NP; p++) begin
            idx = int'(readIndex[p*AW +: AW]);
            if (BYP != 0 && acc && idx == wi) begin
                exp_rd[p] = {writeValid, writeData};
                exp_rk[p] = 1;
            end else if (BYP != 0 && flush_left > 0 && idx == fi) begin
                exp_rd[p] = '0;
                exp_rk[p] = 1;
            end else begin
                exp_rd[p] = m_mem[idx];
                exp_rk[p] = m_known[idx];
            end
        end
        if (acc) begin
            exp_wr = {writeValid, writeData};
            exp_wk = 1;
        end else begin
            exp_wr = m_mem[wi];
            exp_wk = m_known[wi];
        end
        @(posedge clock);
        #1;
        if (flush_left > 0) begin
            m_mem[fi]   = '0;
            m_known[fi] = 1;
            flush_left--;
        end else begin
            if (acc) begin
                m_mem[wi]   = {writeValid, writeData};
                m_known[wi] = 1;
            end
            if (flushRequest) flush_left = DEPTH;
        end
        for (int p = 0; p < NP; p++) begin
            if (exp_rk[p]) begin
                chk($sformatf("rd%0d_data", p), 64'(readData[p*DW +: DW]), 64'(exp_rd[p][DW-1:0]));
                chk($sformatf("rd%0d_valid", p), 64'(readValid[p]), 64'(exp_rd[p][DW]));
            end
        end
        if (exp_wk) begin
            chk("wr_rd_data", 64'(writeReadData), 64'(exp_wr[DW-1:0]));
            chk("wr_rd_valid", 64'(writeReadValid), 64'(exp_wr[DW]));
        end
        chk("flush_busy", 64'(flushBusy), 64'(flush_left > 0));
        chk("write_ready", 64'(writeReady), 64'(flush_left == 0));
    endtask

    // Assert reset mid-cycle, check the asynchronous output values, release at the next falling edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        flush_left = DEPTH;
        chk("rst_read_data", 64'(readData), 64'd0);
        chk("rst_read_valid", 64'(readValid), 64'd0);
        chk("rst_wr_rd_data", 64'(writeReadData), 64'd0);
        chk("rst_wr_rd_valid", 64'(writeReadValid), 64'd0);
        chk("rst_flush_busy", 64'(flushBusy), 64'd1);
        chk("rst_write_ready", 64'(writeReady), 64'd0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Run edges until the flush engine goes idle; returns the number of edges taken.
    task automatic wait_idle(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (flushBusy && n < 200);
    endtask

    int n;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 0;
        end
        flush_left   = 0;
        reset        = 1'b1;
        readIndex    = '0;
        writeIndex   = '0;
        writeData    = '0;
        writeValid   = 1'b0;
        writeEnable  = 1'b0;
        flushRequest = 1'b0;
        #2;

        // 1. Post-reset flush clears preloaded entries in exactly DEPTH edges.
        do_reset();
        dut.mem[3]  = {1'b1, 22'h044444};
        dut.mem[7]  = {1'b1, 22'h344444};
        m_mem[3]    = {1'b1, 22'h044444};
        m_known[3]  = 1;
        m_mem[7]    = {1'b1, 22'h344444};
        m_known[7]  = 1;
        release_reset();
        wait_idle(n);
        chk("t1_flush_edges", 64'(n), 64'd32);
        readIndex = {5'd7, 5'd3};
        cycle();
        chk("t1_rd_idx3", 64'({readValid[0], readData[DW-1:0]}), 64'd0);
        chk("t1_rd_idx7", 64'({readValid[1], readData[2*DW-1:DW]}), 64'd0);

        // 2. Write then read back.
        writeEnable = 1'b1;
        writeIndex  = 5'd10;
        writeData   = 22'h171717;
        writeValid  = 1'b1;
        readIndex   = {5'd2, 5'd10};
        cycle();
        chk("t2_wr_rd_data", 64'(writeReadData), 64'h171717);
        chk("t2_wr_rd_valid", 64'(writeReadValid), 64'd1);
        writeEnable = 1'b0;
        cycle();
        chk("t2_rd0_data", 64'(readData[DW-1:0]), 64'h171717);
        chk("t2_rd0_valid", 64'(readValid[0]), 64'd1);
        chk("t2_rd1_data", 64'(readData[2*DW-1:DW]), 64'h0);
        chk("t2_rd1_valid", 64'(readValid[1]), 64'd0);

        // 3. Same-index collision on all read ports.
        writeEnable = 1'b1;
        writeIndex  = 5'd7;
        writeData   = 22'h344444;
        cycle();
        writeData   = 22'h077007;
        readIndex   = {5'd7, 5'd7};
        cycle();
        chk("t3_rd0_collide", 64'(readData[DW-1:0]), (BYP != 0) ? 64'h077007 : 64'h344444);
        chk("t3_rd1_collide", 64'(readData[2*DW-1:DW]), (BYP != 0) ? 64'h077007 : 64'h344444);
        writeEnable = 1'b0;
        cycle();
        chk("t3_rd0_after", 64'(readData[DW-1:0]), 64'h077007);
        chk("t3_rd1_after", 64'(readData[2*DW-1:DW]), 64'h077007);

        // 4. Write offered during a flush is dropped.
        flushRequest = 1'b1;
        cycle();
        flushRequest = 1'b0;
        writeEnable  = 1'b1;
        writeIndex   = 5'd5;
        writeData    = 22'h003366;
        writeValid   = 1'b1;
        chk("t4_write_ready", 64'(writeReady), 64'd0);
        cycle();
        writeEnable  = 1'b0;
        wait_idle(n);
        chk("t4_flush_done", 64'(flushBusy), 64'd0);
        readIndex = {5'd0, 5'd5};
        cycle();
        chk("t4_rd_idx5", 64'({readValid[0], readData[DW-1:0]}), 64'd0);

        // 5. Reset in the middle of a flush restarts the full sweep.
        writeEnable = 1'b1;
        writeIndex  = 5'd20;
        writeData   = 22'h2abcde;
        cycle();
        writeEnable  = 1'b0;
        flushRequest = 1'b1;
        cycle();
        flushRequest = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        do_reset();
        release_reset();
        wait_idle(n);
        chk("t5_flush_edges", 64'(n), 64'd32);

        // 6. A second request during FLUSH does not extend it.
        flushRequest = 1'b1;
        cycle();
        flushRequest = 1'b0;
        n = 1;
        while (flushBusy && n < 200) begin
            flushRequest = (n == 5);
            cycle();
            n++;
        end
        flushRequest = 1'b0;
        chk("t6_flush_edges", 64'(n), 64'd33);

        // Randomized traffic with frequent index collisions and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            writeEnable  = 1'($urandom_range(0, 1));
            writeIndex   = AW'($urandom_range(0, 7));
            writeData    = DW'($urandom);
            writeValid   = 1'($urandom_range(0, 1));
            readIndex    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            flushRequest = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
